// File: rtl/multiplex_displayer_pkg.sv
// rtl/multiplex_displayer_pkg.sv - shared constants, FSM encoding and 7-segment glyphs
// Purpose: common definitions for the multiplexed decimal display.
// Contents: field/digit widths, select bus width, scan FSM state type,
//           seg7() glyph lookup for decimal digits 0..9 (a..g in bits 0..6).
package multiplex_displayer_pkg;

    localparam int FIELD_W = 6;   // one two-digit field holds 0..63
    localparam int DIGIT_W = 4;   // one decimal digit
    localparam int SEL_W   = 8;   // width of select_dig / select_seg

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // Active-high segment pattern, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] seg7(input logic [DIGIT_W-1:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/multiplex_displayer_bin_to_bcd2.sv
// rtl/multiplex_displayer_bin_to_bcd2.sv - combinational 0..63 to two BCD digits
// Purpose: split a 6-bit field value into tens (0..6) and ones (0..9).
// Ports: value  - binary field value
//        tens   - tens digit
//        ones   - ones digit
module bin_to_bcd2
    import multiplex_displayer_pkg::*;
(
    input  logic [FIELD_W-1:0] value,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones
);

    logic [FIELD_W-1:0] rem;

    // A six-step compare ladder is cheaper than a generic divide for 0..63.
    always_comb begin
        tens = 4'd0;
        rem  = value;
        if (value >= 6'd60) begin
            tens = 4'd6;
            rem  = value - 6'd60;
        end else if (value >= 6'd50) begin
            tens = 4'd5;
            rem  = value - 6'd50;
        end else if (value >= 6'd40) begin
            tens = 4'd4;
            rem  = value - 6'd40;
        end else if (value >= 6'd30) begin
            tens = 4'd3;
            rem  = value - 6'd30;
        end else if (value >= 6'd20) begin
            tens = 4'd2;
            rem  = value - 6'd20;
        end else if (value >= 6'd10) begin
            tens = 4'd1;
            rem  = value - 6'd10;
        end
        ones = rem[DIGIT_W-1:0];
    end

endmodule

// File: rtl/multiplex_displayer.sv
// rtl/multiplex_displayer.sv - time-multiplexed scanner for two-digit decimal fields
// Purpose: scans 2*FIELDS seven-segment digits with hold/blank dwell, per-field
//          blinking and per-digit decimal points; a frame snapshot prevents tearing.
// Ports: clk_1000hz  - clock
//        rst         - asynchronous active-high reset
//        enable      - 1 scans, 0 darkens the display
//        fields      - field f value in bits [6f+5:6f], field 0 rightmost
//        blink_mask  - per-field blink enable
//        dp_mask     - per-digit decimal point
//        select_dig  - registered digit enables, digit k on bit k
//        select_seg  - registered segments a..g on bits 0..6, dp on bit 7
//        frame_start - one-cycle pulse with the first output cycle of digit 0
module multiplex_displayer
    import multiplex_displayer_pkg::*;
#(
    parameter int FIELDS         = 3,
    parameter int HOLD_CYCLES    = 1,
    parameter int BLANK_CYCLES   = 1,
    parameter int BLINK_HALF     = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk_1000hz,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [FIELD_W*FIELDS-1:0] fields,
    input  logic [FIELDS-1:0]         blink_mask,
    input  logic [2*FIELDS-1:0]       dp_mask,
    output logic [SEL_W-1:0]          select_dig,
    output logic [SEL_W-1:0]          select_seg,
    output logic                      frame_start
);

    localparam int          D          = 2 * FIELDS;
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] BLANK_LAST = 16'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [2:0]  IDX_LAST   = 3'(D - 1);
    localparam int          BW         = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [SEL_W-1:0] DIG_OFF = DIG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [SEL_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    state_t      state, state_n;
    logic [2:0]  idx, idx_n, idx_inc;
    logic [15:0] dwell, dwell_n;
    logic        enter_show;

    logic [FIELD_W*FIELDS-1:0] snap_fields;
    logic [FIELDS-1:0]         snap_blink;
    logic [D-1:0]              snap_dp;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;   // 1 = on
    logic          show_phase;    // phase frozen at SHOW entry

    logic [23:0]        fields_pad;
    logic [3:0]         blink_pad;
    logic [7:0]         dp_pad;
    logic [1:0]         field_sel;
    logic [DIGIT_W-1:0] tens, ones, digit;
    logic               lit, fs_n;
    logic [SEL_W-1:0]   dig_raw_n, seg_raw_n;

    assign idx_inc = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;

    // State register; snapshot and blink phase are latched on SHOW entry.
    always_ff @(posedge clk_1000hz or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= 3'd0;
            dwell       <= 16'd0;
            snap_fields <= '0;
            snap_blink  <= '0;
            snap_dp     <= '0;
            show_phase  <= 1'b1;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            dwell <= dwell_n;
            if (enter_show) begin
                show_phase <= blink_phase;
                if (idx_n == 3'd0) begin
                    snap_fields <= fields;
                    snap_blink  <= blink_mask;
                    snap_dp     <= dp_mask;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        dwell_n    = dwell + 16'd1;
        enter_show = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
            idx_n   = 3'd0;
            dwell_n = 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n    = ST_SHOW;
                    idx_n      = 3'd0;
                    dwell_n    = 16'd0;
                    enter_show = 1'b1;
                end
                ST_SHOW: begin
                    if (dwell == HOLD_LAST) begin
                        dwell_n = 16'd0;
                        if (BLANK_CYCLES == 0) begin
                            idx_n      = idx_inc;
                            enter_show = 1'b1;
                        end else begin
                            state_n = ST_BLANK;
                        end
                    end
                end
                ST_BLANK: begin
                    if (dwell == BLANK_LAST) begin
                        state_n    = ST_SHOW;
                        idx_n      = idx_inc;
                        dwell_n    = 16'd0;
                        enter_show = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    idx_n   = 3'd0;
                    dwell_n = 16'd0;
                end
            endcase
        end
    end

    // Free-running blink timebase, independent of enable.
    always_ff @(posedge clk_1000hz or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign fields_pad = 24'(snap_fields);
    assign blink_pad  = 4'(snap_blink);
    assign dp_pad     = 8'(snap_dp);
    assign field_sel  = idx[2:1];

    bin_to_bcd2 u_bcd (
        .value (fields_pad[FIELD_W*field_sel +: FIELD_W]),
        .tens  (tens),
        .ones  (ones)
    );

    // Output logic: the register below is loaded from this, so digit and
    // segments always come from the same idx in the same cycle.
    always_comb begin
        digit     = idx[0] ? tens : ones;
        lit       = enable && (state == ST_SHOW) && !(blink_pad[field_sel] && !show_phase);
        dig_raw_n = lit ? (8'b1 << idx) : 8'h00;
        seg_raw_n = lit ? {dp_pad[idx], seg7(digit)} : 8'h00;
        fs_n      = enable && (state == ST_SHOW) && (idx == 3'd0) && (dwell == 16'd0);
    end

    always_ff @(posedge clk_1000hz or posedge rst) begin
        if (rst) begin
            select_dig  <= DIG_OFF;
            select_seg  <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            select_dig  <= dig_raw_n ^ DIG_OFF;
            select_seg  <= seg_raw_n ^ SEG_OFF;
            frame_start <= fs_n;
        end
    end

endmodule

// File: tb/tb_multiplex_displayer.sv
// tb/tb_multiplex_displayer.sv - directed self-checking bench for multiplex_displayer
module tb_multiplex_displayer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [17:0] fields_a;
    logic [2:0]  blink_a;
    logic [5:0]  dp_a;
    logic [23:0] fields_b;
    logic [3:0]  blink_b;
    logic [7:0]  dp_b;
    logic [7:0]  dig_a, seg_a, dig_b, seg_b;
    logic        fs_a, fs_b;

    int errors = 0;
    int checks = 0;

    logic [6:0] glyph [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [7:0] exp_dig [0:15];
    logic [7:0] exp_seg [0:15];
    int         flen;

    always #5 clk = ~clk;

    multiplex_displayer #(.BLINK_HALF(6)) dut_a (
        .clk_1000hz (clk),
        .rst        (rst),
        .enable     (en_a),
        .fields     (fields_a),
        .blink_mask (blink_a),
        .dp_mask    (dp_a),
        .select_dig (dig_a),
        .select_seg (seg_a),
        .frame_start(fs_a)
    );

    multiplex_displayer #(.FIELDS(4), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk_1000hz (clk),
        .rst        (rst),
        .enable     (en_b),
        .fields     (fields_b),
        .blink_mask (blink_b),
        .dp_mask    (dp_b),
        .select_dig (dig_b),
        .select_seg (seg_b),
        .frame_start(fs_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Expected per-cycle outputs for one frame; digs nibble k is digit k.
    task automatic build(input int n, input logic [31:0] digs, input logic [7:0] dark,
                         input logic [7:0] dp, input bit inv, input bit gaps);
        int j;
        logic [7:0] raw;
        flen = gaps ? 2 * n : n;
        for (int k = 0; k < flen; k++) begin
            j = gaps ? k / 2 : k;
            if ((gaps && (k % 2 == 1)) || dark[j]) begin
                exp_dig[k] = 8'hFF;
                raw        = 8'h00;
            end else begin
                exp_dig[k] = ~(8'b1 << j);
                raw        = {dp[j], glyph[digs[4*j +: 4]]};
            end
            exp_seg[k] = inv ? ~raw : raw;
        end
    endtask

    // Wait for frame_start (bounded), then check one frame cycle by cycle.
    task automatic run_frame(input string nm, input int which, input int exp_wait,
                             input int chg_at, input logic [17:0] chg_val);
        int   waited;
        logic fs;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
            fs = (which == 1) ? fs_b : fs_a;
        end while (!fs && waited < 40);
        if (exp_wait > 0) chk({nm, "_wait"}, waited, exp_wait);
        for (int k = 0; k < flen; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("%s_dig%0d", nm, k), (which == 1) ? dig_b : dig_a, exp_dig[k]);
            chk($sformatf("%s_seg%0d", nm, k), (which == 1) ? seg_b : seg_a, exp_seg[k]);
            chk($sformatf("%s_fs%0d", nm, k), (which == 1) ? fs_b : fs_a, (k == 0) ? 1 : 0);
            if (k == chg_at) fields_a = chg_val;
        end
    endtask

    task automatic sync_a(input string nm);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!fs_a && waited < 40);
        chk({nm, "_sync"}, fs_a, 1);
    endtask

    initial begin
        rst      = 1'b1;
        en_a     = 1'b1;
        en_b     = 1'b1;
        fields_a = {6'd12, 6'd34, 6'd56};
        blink_a  = 3'b000;
        dp_a     = 6'b0;
        fields_b = {6'd19, 6'd63, 6'd40, 6'd7};
        blink_b  = 4'b0;
        dp_b     = 8'b0000_0100;

        repeat (3) @(negedge clk);
        chk("rst_dig_a", dig_a, 8'hFF);
        chk("rst_seg_a", seg_a, 8'h00);
        chk("rst_fs_a", fs_a, 0);
        chk("rst_dig_b", dig_b, 8'hFF);
        chk("rst_seg_b", seg_b, 8'hFF);
        chk("rst_fs_b", fs_b, 0);
        rst = 1'b0;

        // 4 fields, no blank gap, inverted segments, dp on digit 2.
        build(8, 32'h1963_4007, 8'h00, 8'h04, 1'b1, 1'b0);
        run_frame("b0", 1, 2, -1, '0);
        run_frame("b1", 1, 1, -1, '0);

        // 12:34:56 with defaults.
        build(6, 32'h0012_3456, 8'h00, 8'h00, 1'b0, 1'b1);
        run_frame("a0", 0, -1, -1, '0);
        fields_a = {6'd12, 6'd34, 6'd59};
        run_frame("a1", 0, 1, -1, '0);

        // 59 frame; seconds cleared mid-frame must not tear it.
        build(6, 32'h0012_3459, 8'h00, 8'h00, 1'b0, 1'b1);
        run_frame("tear59", 0, 1, 5, {6'd12, 6'd34, 6'd0});
        build(6, 32'h0012_3400, 8'h00, 8'h00, 1'b0, 1'b1);
        run_frame("tear00", 0, 1, -1, '0);

        // Minute field blinks: with a 12-cycle frame and 6-cycle half period
        // from reset, the minute tens slot always lands in the off phase.
        blink_a = 3'b010;
        run_frame("pre_blink", 0, 1, -1, '0);
        build(6, 32'h0012_3400, 8'b0000_1000, 8'h00, 1'b0, 1'b1);
        run_frame("blink0", 0, 1, -1, '0);
        run_frame("blink1", 0, 1, -1, '0);
        blink_a = 3'b000;

        // Enable dropped while digit 4 is being shown.
        sync_a("en");
        repeat (7) @(negedge clk);
        chk("en_k7_dig", dig_a, 8'hFF);
        en_a = 1'b0;
        @(negedge clk);
        chk("en_off_dig", dig_a, 8'hFF);
        chk("en_off_seg", seg_a, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("idle_dig%0d", i), dig_a, 8'hFF);
            chk($sformatf("idle_fs%0d", i), fs_a, 0);
        end
        en_a = 1'b1;
        build(6, 32'h0012_3400, 8'h00, 8'h00, 1'b0, 1'b1);
        run_frame("reen", 0, 2, -1, '0);

        // Asynchronous reset while digit 3 is lit.
        sync_a("rstm");
        repeat (6) @(negedge clk);
        chk("rstm_pre_dig", dig_a, 8'hF7);
        rst = 1'b1;
        #1;
        chk("rstm_dig", dig_a, 8'hFF);
        chk("rstm_seg", seg_a, 8'h00);
        chk("rstm_fs", fs_a, 0);
        @(negedge clk);
        rst = 1'b0;
        run_frame("post_rst", 0, 2, -1, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
